// File: rtl/uart_rx_core.sv
// uart_rx_core: 16x-oversampled UART receiver with start-bit validation, optional parity and stop-bit checks.
module uart_rx_core #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);
  localparam int unsigned BW = $clog2(DATA_BITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic rx_m, rx_s;
  logic [3:0] tick_cnt, tick_cnt_n;
  logic [BW-1:0] bit_idx, bit_idx_n;
  logic [DATA_BITS-1:0] shift, shift_n, rx_data_n;
  logic par_bit, par_bit_n, rx_valid_n, parity_err_n, frame_err_n;
  logic tc_end, last_bit, mismatch;
  assign tc_end   = tick_cnt == 4'd15;
  assign last_bit = bit_idx == BW'(DATA_BITS - 1);
  assign mismatch = (^{shift, par_bit}) ^ (PARITY_ODD != 0);
  assign rx_busy  = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      par_bit    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      state      <= state_n;
      tick_cnt   <= tick_cnt_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      par_bit    <= par_bit_n;
      rx_data    <= rx_data_n;
      rx_valid   <= rx_valid_n;
      parity_err <= parity_err_n;
      frame_err  <= frame_err_n;
    end
  end
  // Shift in at the MSB so the first bit on the line lands in the LSB after DATA_BITS samples.
  always_comb begin
    state_n      = state;
    tick_cnt_n   = tick_cnt;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    par_bit_n    = par_bit;
    rx_data_n    = rx_data;
    parity_err_n = parity_err;
    frame_err_n  = frame_err;
    rx_valid_n   = 1'b0;
    if (sample_tick) begin
      case (state)
        IDLE: begin
          state_n    = rx_s ? IDLE : START;
          tick_cnt_n = '0;
        end
        START: begin
          tick_cnt_n = tick_cnt == 4'd7 ? 4'd0 : tick_cnt + 4'd1;
          bit_idx_n  = '0;
          state_n    = tick_cnt != 4'd7 ? START : rx_s ? IDLE : DATA;
        end
        DATA: begin
          tick_cnt_n = tc_end ? 4'd0 : tick_cnt + 4'd1;
          if (tc_end) begin
            shift_n   = {rx_s, shift[DATA_BITS-1:1]};
            bit_idx_n = last_bit ? bit_idx : bit_idx + 1'b1;
            state_n   = !last_bit ? DATA : (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: begin
          tick_cnt_n = tc_end ? 4'd0 : tick_cnt + 4'd1;
          par_bit_n  = tc_end ? rx_s : par_bit;
          state_n    = tc_end ? STOP : PARITY;
        end
        STOP: begin
          tick_cnt_n = tc_end ? 4'd0 : tick_cnt + 4'd1;
          if (tc_end) begin
            rx_data_n    = shift;
            parity_err_n = (PARITY_EN != 0) & mismatch;
            frame_err_n  = ~rx_s;
            rx_valid_n   = 1'b1;
            state_n      = rx_s ? IDLE : WAIT_IDLE;
          end
        end
        WAIT_IDLE: state_n = rx_s ? IDLE : WAIT_IDLE;
        default:   state_n = IDLE;
      endcase
    end
  end
endmodule
